// File: rtl/kicker_pkg.sv
// Shared types and default sizing for the solenoid kicker controller.
package kicker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    COOL = 2'd2
  } kick_state_e;

  localparam int N_CH_DEF  = 2;
  localparam int CNT_W_DEF = 24;

endpackage

// File: rtl/kicker_chan.sv
// One kicker channel: enable synchroniser, rise detector, IDLE/KICK/COOL FSM
// and a shared down-counter for pulse and cooldown timing.
module kicker_chan
  import kicker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             arm_i,
  input  logic [CNT_W-1:0] pulse_len_i,
  input  logic [CNT_W-1:0] cool_len_i,
  input  logic             clr_fault_i,
  output logic             kick_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o
);

  logic             meta_q, sync_q1, sync_q2;
  kick_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             kick_q, busy_q, done_q, fault_q;
  logic             rise;
  logic             set_fault;
  logic [CNT_W-1:0] pulse_load;

  assign rise       = sync_q1 & ~sync_q2;
  assign pulse_load = (pulse_len_i == '0) ? CNT_W'(1) : pulse_len_i;
  // A rise during the final COOL cycle is still seen in COOL, so it is rejected.
  assign set_fault  = (rise && (state_q != IDLE || !arm_i)) ||
                      (state_q == KICK && !arm_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      meta_q  <= enable_i;
      sync_q1 <= meta_q;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= set_fault | (fault_q & ~clr_fault_i);
      unique case (state_q)
        IDLE: begin
          if (rise && arm_i) begin
            state_q <= KICK;
            cnt_q   <= pulse_load;
            kick_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        KICK: begin
          if (!arm_i || cnt_q == CNT_W'(1)) begin
            kick_q <= 1'b0;
            if (cool_len_i == '0) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= COOL;
              cnt_q   <= cool_len_i;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        COOL: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          kick_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign kick_o  = kick_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/kicker_ctrl.sv
// Multi-channel solenoid kicker controller: N_CH independent kicker_chan
// instances sharing arm, pulse/cooldown lengths and fault clear.
module kicker_ctrl
  import kicker_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  enable,
  input  logic             arm,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] cool_len,
  input  logic             clr_fault,
  output logic [N_CH-1:0]  kick,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done,
  output logic [N_CH-1:0]  fault
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    kicker_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable[g]),
      .arm_i      (arm),
      .pulse_len_i(pulse_len),
      .cool_len_i (cool_len),
      .clr_fault_i(clr_fault),
      .kick_o     (kick[g]),
      .busy_o     (busy[g]),
      .done_o     (done[g]),
      .fault_o    (fault[g])
    );
  end

endmodule

// File: tb/tb_kicker_ctrl.sv
// Self-checking bench for kicker_ctrl: directed scenarios plus random traffic
// against a timestamp-window reference model.
module tb_kicker_ctrl;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] enable;
  logic           arm;
  logic [CW-1:0]  pulse_len;
  logic [CW-1:0]  cool_len;
  logic           clr_fault;
  logic [NCH-1:0] kick, busy, done, fault;

  int checks = 0;
  int errors = 0;

  kicker_ctrl #(.N_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .arm(arm),
    .pulse_len(pulse_len), .cool_len(cool_len), .clr_fault(clr_fault),
    .kick(kick), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: each kick is a pair of time windows [ks,ke) and [ks,ce)
  // measured in clock-edge counts; enable samples kept as a short history.
  longint cyc = 0;
  longint ks[NCH], ke[NCH], ce[NCH];
  logic   h0[NCH], h1[NCH], h2[NCH];
  logic [NCH-1:0] m_kick, m_busy, m_done, m_fault;

  function automatic bit inwin(longint t, longint a, longint b);
    return (t >= a) && (t < b);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      ks[ch] = -100; ke[ch] = -100; ce[ch] = -100;
      h0[ch] = 1'b0; h1[ch] = 1'b0; h2[ch] = 1'b0;
    end
    m_kick = '0; m_busy = '0; m_done = '0; m_fault = '0;
  endtask

  task automatic model_step();
    bit rise, busy_p, kick_p, setf;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      rise   = h1[ch] & ~h2[ch];
      busy_p = inwin(cyc - 1, ks[ch], ce[ch]);
      kick_p = inwin(cyc - 1, ks[ch], ke[ch]);
      setf   = 1'b0;
      if (!busy_p) begin
        if (rise) begin
          if (arm) begin
            ks[ch] = cyc;
            ke[ch] = (pulse_len == 0) ? cyc + 1 : cyc + longint'(pulse_len);
            ce[ch] = ke[ch];
          end else setf = 1'b1;
        end
      end else begin
        if (rise) setf = 1'b1;
        if (kick_p) begin
          if (!arm) begin
            ke[ch] = cyc;
            ce[ch] = cyc + longint'(cool_len);
            setf   = 1'b1;
          end else if (cyc == ke[ch]) begin
            ce[ch] = cyc + longint'(cool_len);
          end
        end
      end
      m_fault[ch] = (m_fault[ch] & ~clr_fault) | setf;
      m_kick[ch]  = inwin(cyc, ks[ch], ke[ch]);
      m_busy[ch]  = inwin(cyc, ks[ch], ce[ch]);
      m_done[ch]  = busy_p & ~m_busy[ch];
      h2[ch] = h1[ch]; h1[ch] = h0[ch]; h0[ch] = enable[ch];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = '0; arm = 1'b1; pulse_len = '0; cool_len = '0; clr_fault = 1'b0;
    #1;
    checks++;
    if ({kick, busy, done, fault} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b exp 0", {kick, busy, done, fault});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({kick, busy, done, fault} !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b exp 0", i, {kick, busy, done, fault});
      end
    end
  endtask

  task automatic test_basic();
    int nk = 0, nb = 0, nd = 0, first = -1;
    pulse_len = 8'd5; cool_len = 8'd10; arm = 1'b1;
    enable[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 20) enable[0] = 1'b0;
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL basic cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      if (kick[0] && first < 0) first = i + 1;
      nk += int'(kick[0]); nb += int'(busy[0]); nd += int'(done[0]);
    end
    checks++;
    if (first !== 3 || nk !== 5 || nb !== 15 || nd !== 1 || fault[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_summary: got first=%0d kick=%0d busy=%0d done=%0d fault=%b exp 3 5 15 1 0",
               first, nk, nb, nd, fault[0]);
    end
  endtask

  task automatic test_reject();
    int nk = 0, nb = 0, nd = 0, first = -1;
    pulse_len = 8'd5; cool_len = 8'd10;
    enable[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 3) enable[0] = 1'b0;
      if (i == 6) enable[0] = 1'b1;
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL reject cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      if (kick[0] && first < 0) first = i + 1;
      nk += int'(kick[0]); nb += int'(busy[0]); nd += int'(done[0]);
    end
    checks++;
    if (first !== 3 || nk !== 5 || nb !== 15 || nd !== 1 || fault[0] !== 1'b1) begin
      errors++;
      $display("FAIL reject_summary: got first=%0d kick=%0d busy=%0d done=%0d fault=%b exp 3 5 15 1 1",
               first, nk, nb, nd, fault[0]);
    end
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    enable[0] = 1'b0;
    checks++;
    if (fault !== 2'b00 || m_fault !== 2'b00) begin
      errors++;
      $display("FAIL reject_clear: got fault=%b model=%b exp 00", fault, m_fault);
    end
    repeat (4) step();
  endtask

  task automatic test_arm_abort();
    int nk = 0, nc = 0, nd = 0;
    pulse_len = 8'd100; cool_len = 8'd10; arm = 1'b1;
    enable[0] = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step();
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL arm_abort cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      nk += int'(kick[0]); nc += int'(busy[0] & ~kick[0]); nd += int'(done[0]);
      if (nk == 20 && kick[0]) arm = 1'b0;
    end
    checks++;
    if (nk !== 20 || nc !== 10 || nd !== 1 || fault[0] !== 1'b1) begin
      errors++;
      $display("FAIL arm_abort_summary: got kick=%0d cool=%0d done=%0d fault=%b exp 20 10 1 1",
               nk, nc, nd, fault[0]);
    end
    arm = 1'b1; enable[0] = 1'b0; clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_simultaneous();
    int kedge[NCH], dedge[NCH], nk[NCH];
    for (int ch = 0; ch < NCH; ch++) begin kedge[ch] = -1; dedge[ch] = -1; nk[ch] = 0; end
    pulse_len = 8'd0; cool_len = 8'd0;
    enable = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL simul cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      for (int ch = 0; ch < NCH; ch++) begin
        nk[ch] += int'(kick[ch]);
        if (kick[ch] && kedge[ch] < 0) kedge[ch] = i + 1;
        if (done[ch] && dedge[ch] < 0) dedge[ch] = i + 1;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (nk[ch] !== 1 || kedge[ch] !== 3 || dedge[ch] !== 4) begin
        errors++;
        $display("FAIL simul_ch%0d: got kicks=%0d kick_edge=%0d done_edge=%0d exp 1 3 4",
                 ch, nk[ch], kedge[ch], dedge[ch]);
      end
    end
    enable = 2'b00;
    repeat (4) step();
  endtask

  task automatic test_unarmed();
    int nk = 0;
    arm = 1'b0; pulse_len = 8'd3; cool_len = 8'd2;
    enable[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL unarmed cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      nk += int'(kick[1]);
    end
    checks++;
    if (nk !== 0 || fault !== 2'b10) begin
      errors++;
      $display("FAIL unarmed_summary: got kicks=%0d fault=%b exp 0 10", nk, fault);
    end
    arm = 1'b1; enable[1] = 1'b0; clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_all_ones();
    int nk = 0, nd = 0;
    pulse_len = '1; cool_len = 8'd3;
    enable[1] = 1'b1;
    for (int i = 0; i < 270; i++) begin
      step();
      if (i == 10) pulse_len = 8'd2;
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL all_ones cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      nk += int'(kick[1]); nd += int'(done[1]);
    end
    checks++;
    if (nk !== 255 || nd !== 1) begin
      errors++;
      $display("FAIL all_ones_summary: got kicks=%0d done=%0d exp 255 1", nk, nd);
    end
    enable[1] = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    int first = -1, nd = 0;
    pulse_len = 8'd50; cool_len = 8'd5;
    enable[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (arm && i == 5) enable[1] = 1'b0;
    end
    checks++;
    if (kick[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got kick0=%b exp 1", kick[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({kick, busy, done, fault} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b exp 0", {kick, busy, done, fault});
    end
    repeat (2) begin
      @(posedge clk);
      nd += int'(|done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
      if (kick[0] && first < 0) first = i + 1;
      nd += int'(|done);
    end
    checks++;
    if (first !== 3 || nd !== 0) begin
      errors++;
      $display("FAIL reset_mid_summary: got kick_edge=%0d done_pulses=%0d exp 3 0", first, nd);
    end
    enable[0] = 1'b0;
    repeat (60) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) enable[0] = ~enable[0];
      if ($urandom_range(0, 9) == 0) enable[1] = ~enable[1];
      arm       = ($urandom_range(0, 19) != 0);
      clr_fault = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 7) == 0) pulse_len = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) cool_len  = CW'($urandom_range(0, 6));
      step();
      checks++;
      if ({kick, busy, done, fault} !== {m_kick, m_busy, m_done, m_fault}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b exp %b", i, {kick, busy, done, fault},
                 {m_kick, m_busy, m_done, m_fault});
      end
    end
    arm = 1'b1; clr_fault = 1'b0; enable = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_arm_abort();
    test_simultaneous();
    test_unarmed();
    test_all_ones();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
